// File: rtl/poly_pkg.sv
// poly_pkg: shared definitions for the polynomial-engine command scheduler.
// Holds opcodes, scheduler status codes, the FSM state encoding and the
// command-word field layout, plus a helper that splits a raw command word.
package poly_pkg;

  // Opcodes, command word bits [31:29]
  localparam logic [2:0] OP_SETUP = 3'b001;
  localparam logic [2:0] OP_EVP   = 3'b010;
  localparam logic [2:0] OP_EVB   = 3'b011;
  localparam logic [2:0] OP_CLEAR = 3'b100;

  // Status codes generated by the scheduler itself
  localparam logic [31:0] ST_OK           = 32'd0;
  localparam logic [31:0] ST_INVALID_SLOT = 32'd1;
  localparam logic [31:0] ST_BAD_COUNT    = 32'd2;
  localparam logic [31:0] ST_BAD_OPCODE   = 32'd3;
  localparam logic [31:0] ST_TIMEOUT      = 32'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  // Command-word field positions (LSB of each field)
  localparam int CMD_OP_LSB   = 29;
  localparam int CMD_SLOT_LSB = 26;
  localparam int CMD_ARG_LSB  = 21;

  // arg is N for SETUP, b for EVP/EVB
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] slot;
    logic [4:0] arg;
  } cmd_t;

  function automatic cmd_t cmd_unpack(input logic [31:0] w);
    cmd_t c;
    c.op   = w[CMD_OP_LSB   +: 3];
    c.slot = w[CMD_SLOT_LSB +: 3];
    c.arg  = w[CMD_ARG_LSB  +: 5];
    return c;
  endfunction

endpackage

// File: rtl/poly_slot_table.sv
// poly_slot_table: 8-entry degree table {valid, N[4:0]} used by the scheduler.
// Ports: clk_i/rst_ni; write port wr_en_i/wr_slot_i/wr_n_i; clr_i clears all
// valid bits; combinational read rd_slot_i -> rd_valid_o/rd_n_o. Writes land on the edge.
module poly_slot_table (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_en_i,
  input  logic [2:0] wr_slot_i,
  input  logic [4:0] wr_n_i,
  input  logic       clr_i,
  input  logic [2:0] rd_slot_i,
  output logic       rd_valid_o,
  output logic [4:0] rd_n_o
);

  logic [7:0]      valid_q;
  logic [7:0][4:0] n_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      n_q     <= '0;
    end else begin
      if (clr_i) begin
        valid_q <= '0;
      end else if (wr_en_i) begin
        valid_q[wr_slot_i] <= 1'b1;
      end
      if (wr_en_i) begin
        n_q[wr_slot_i] <= wr_n_i;
      end
    end
  end

  assign rd_valid_o = valid_q[rd_slot_i];
  assign rd_n_o     = n_q[rd_slot_i];

endmodule

// File: rtl/poly_cmd_sched.sv
// poly_cmd_sched: one-at-a-time command scheduler for the polynomial engine.
// Ports: cmd_* command in (valid/ready), eng_* engine launch/abort/done, rsp_* response out.
// Latency: SETUP/CLEAR/errors respond 2 cycles after accept; engine runs respond 1 cycle
// after done or watchdog expiry. cmd_ready only in IDLE; responses held until rsp_ready.
module poly_cmd_sched
  import poly_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  output logic        eng_start,
  output logic        eng_abort,
  output logic [2:0]  eng_A,
  output logic [4:0]  eng_b,
  output logic [4:0]  eng_N,
  input  logic        eng_done,
  input  logic [31:0] eng_result,
  input  logic [31:0] eng_status,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] rsp_status
);

  // Last WAIT cycle before expiry: the watchdog has counted TIMEOUT_CYCLES
  // WAIT cycles once it would step past this value.
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [15:0] wdog_q, wdog_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        eng_start_q, eng_start_d;
  logic        eng_abort_q, eng_abort_d;
  logic [2:0]  eng_a_q, eng_a_d;
  logic [4:0]  eng_b_q, eng_b_d;
  logic [4:0]  eng_n_q, eng_n_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [31:0] rsp_status_q, rsp_status_d;

  logic        tbl_wr, tbl_clr, tbl_vld;
  logic [4:0]  tbl_n;

  // Reserved command bits are deliberately ignored.
  logic unused_rsvd;
  assign unused_rsvd = ^cmd_data[CMD_ARG_LSB-1:0];

  poly_slot_table u_table (
    .clk_i      (clk),
    .rst_ni     (rst),
    .wr_en_i    (tbl_wr),
    .wr_slot_i  (cmd_q.slot),
    .wr_n_i     (cmd_q.arg),
    .clr_i      (tbl_clr),
    .rd_slot_i  (cmd_q.slot),
    .rd_valid_o (tbl_vld),
    .rd_n_o     (tbl_n)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    wdog_d       = wdog_q;
    eng_start_d  = 1'b0;
    eng_abort_d  = 1'b0;
    eng_a_d      = eng_a_q;
    eng_b_d      = eng_b_q;
    eng_n_d      = eng_n_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_status_d = rsp_status_q;
    tbl_wr       = 1'b0;
    tbl_clr      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_d   = cmd_unpack(cmd_data);
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // Default outcome is an immediate response; only a legal eval launches.
        state_d      = S_RESP;
        rsp_valid_d  = 1'b1;
        rsp_result_d = '0;
        rsp_status_d = ST_OK;
        case (cmd_q.op)
          OP_SETUP: tbl_wr  = 1'b1;
          OP_CLEAR: tbl_clr = 1'b1;
          OP_EVP, OP_EVB: begin
            if (!tbl_vld) begin
              rsp_status_d = ST_INVALID_SLOT;
            end else if (cmd_q.op == OP_EVB && cmd_q.arg == 5'd0) begin
              rsp_status_d = ST_BAD_COUNT;
            end else begin
              state_d     = S_LAUNCH;
              rsp_valid_d = 1'b0;
              eng_start_d = 1'b1;
              eng_a_d     = cmd_q.slot;
              eng_b_d     = (cmd_q.op == OP_EVP) ? 5'd1 : cmd_q.arg;
              eng_n_d     = tbl_n;
            end
          end
          default: rsp_status_d = ST_BAD_OPCODE;
        endcase
      end

      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // A done landing on the expiry cycle takes precedence over the abort.
        if (eng_done) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = eng_result;
          rsp_status_d = eng_status;
        end else if (wdog_q == WDOG_LAST) begin
          state_d      = S_RESP;
          eng_abort_d  = 1'b1;
          rsp_valid_d  = 1'b1;
          rsp_result_d = '0;
          rsp_status_d = ST_TIMEOUT;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      wdog_q       <= '0;
      cmd_ready_q  <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_abort_q  <= 1'b0;
      eng_a_q      <= '0;
      eng_b_q      <= '0;
      eng_n_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      wdog_q       <= wdog_d;
      cmd_ready_q  <= cmd_ready_d;
      eng_start_q  <= eng_start_d;
      eng_abort_q  <= eng_abort_d;
      eng_a_q      <= eng_a_d;
      eng_b_q      <= eng_b_d;
      eng_n_q      <= eng_n_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign eng_start  = eng_start_q;
  assign eng_abort  = eng_abort_q;
  assign eng_A      = eng_a_q;
  assign eng_b      = eng_b_q;
  assign eng_N      = eng_n_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_poly_cmd_sched.sv
// tb_poly_cmd_sched: directed bench for poly_cmd_sched with a response scoreboard.
// Stimulus pushes expected {result,status}; a negedge monitor pops on each handshake.
// A small engine model answers eng_start after a programmable delay (or never).
module tb_poly_cmd_sched;

  // Watchdog limit of this instance; long enough for the 20-cycle engine run.
  localparam int TO = 24;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_data;
  logic        eng_start, eng_abort;
  logic [2:0]  eng_A;
  logic [4:0]  eng_b, eng_N;
  logic        eng_done, eng_done_m, eng_done_s;
  logic [31:0] eng_result, eng_status;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result, rsp_status;

  assign eng_done = eng_done_m | eng_done_s;

  poly_cmd_sched #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .eng_start(eng_start), .eng_abort(eng_abort),
    .eng_A(eng_A), .eng_b(eng_b), .eng_N(eng_N),
    .eng_done(eng_done), .eng_result(eng_result), .eng_status(eng_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_status(rsp_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic [31:0] st;
  } exp_t;
  exp_t exp_q[$];

  task automatic push(input logic [31:0] res, input logic [31:0] st);
    exp_t e;
    e.res = res;
    e.st  = st;
    exp_q.push_back(e);
  endtask

  // ---------------- engine model ----------------
  int          eng_delay = -1;
  logic [31:0] eng_res_v, eng_st_v;
  int          start_cnt = 0, start_cyc = 0, done_cyc = 0;
  logic [2:0]  st_A;
  logic [4:0]  st_b, st_N;

  always begin
    @(negedge clk);
    if (rst && eng_start) begin
      start_cnt++;
      start_cyc = cyc;
      st_A = eng_A;
      st_b = eng_b;
      st_N = eng_N;
      if (eng_delay >= 0) begin
        repeat (eng_delay) @(posedge clk);
        #1;
        eng_done_m = 1'b1;
        eng_result = eng_res_v;
        eng_status = eng_st_v;
        done_cyc   = cyc;
        @(posedge clk);
        #1;
        eng_done_m = 1'b0;
        eng_result = 32'hDEAD_BEEF;
        eng_status = 32'hDEAD_BEEF;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          abort_cnt = 0, abort_cyc = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] prev_res, prev_st;

  always @(negedge clk) begin
    if (rst) begin
      if (hold_pend)
        chk("rsp_hold_stable", {rsp_valid, rsp_result, rsp_status}, {1'b1, prev_res, prev_st});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_rsp: got result 0x%0h status %0d, expected none", rsp_result, rsp_status);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_status", rsp_status, e.st);
        end
      end
      if (eng_abort) begin
        abort_cnt++;
        abort_cyc = cyc;
      end
      hold_pend = rsp_valid && !rsp_ready;
      prev_res  = rsp_result;
      prev_st   = rsp_status;
    end else begin
      hold_pend = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] mk(input logic [2:0] op, input logic [2:0] a, input logic [4:0] n);
    return {op, a, n, 21'h0};
  endfunction

  // Returns the cycle in which the command was accepted.
  task automatic send(input logic [31:0] d, output int t);
    int w;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = d;
    w = 0;
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL cmd_accept_timeout: got cmd_ready 0, expected 1 within 200 cycles");
    end
    t = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 32'h0;
  endtask

  // Returns the first cycle in which rsp_valid is seen high.
  task automatic wait_rsp(output int r);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!rsp_valid && w < 200);
    if (!rsp_valid) begin
      n_vec++;
      n_bad++;
      $display("FAIL rsp_timeout: got rsp_valid 0, expected 1 within 200 cycles");
    end
    r = cyc;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t, r, sc, ac, rr;
    cmd_valid  = 1'b0;
    cmd_data   = '0;
    rsp_ready  = 1'b1;
    eng_done_m = 1'b0;
    eng_done_s = 1'b0;
    eng_result = '0;
    eng_status = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("reset_outputs", {cmd_ready, eng_start, eng_abort, eng_A, eng_b, eng_N, rsp_valid},
        {1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 1'b0});
    chk("reset_rsp_data", {rsp_result, rsp_status}, 64'd0);
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready_held", cmd_ready, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 1'b1);

    // SETUP A=3 N=4
    push(32'h0, 32'd0);
    send(mk(3'b001, 3'd3, 5'd4), t);
    wait_rsp(r);
    chk("setup_latency", r, t + 2);

    // EVB A=3 b=5, engine answers 20 cycles after start
    eng_delay = 20; eng_res_v = 32'h1234; eng_st_v = 32'h0;
    sc = start_cnt;
    push(32'h1234, 32'd0);
    send(mk(3'b011, 3'd3, 5'd5), t);
    wait_rsp(r);
    chk("evb_start_pulses", start_cnt - sc, 1);
    chk("evb_start_cycle", start_cyc, t + 2);
    chk("evb_eng_args", {st_A, st_b, st_N}, {3'd3, 5'd5, 5'd4});
    chk("evb_rsp_latency", r, t + 23);

    // Error responses: none of these may launch the engine
    sc = start_cnt;
    push(32'h0, 32'd1);
    send(mk(3'b010, 3'd6, 5'd0), t);
    wait_rsp(r);
    chk("invalid_slot_latency", r, t + 2);
    push(32'h0, 32'd2);
    send(mk(3'b011, 3'd3, 5'd0), t);
    wait_rsp(r);
    push(32'h0, 32'd3);
    send(mk(3'b111, 3'd3, 5'd1), t);
    wait_rsp(r);
    push(32'h0, 32'd3);                      // bad opcode outranks invalid slot
    send(mk(3'b000, 3'd6, 5'd0), t);
    wait_rsp(r);
    chk("errors_no_start", start_cnt - sc, 0);

    // EVP ignores the b field and forces b=1; engine status passes through
    eng_delay = 5; eng_res_v = 32'hCAFE_F00D; eng_st_v = 32'h0000_00A5;
    push(32'hCAFE_F00D, 32'h0000_00A5);
    send(mk(3'b010, 3'd3, 5'd0), t);
    wait_rsp(r);
    chk("evp_eng_args", {st_A, st_b, st_N}, {3'd3, 5'd1, 5'd4});

    // Overwrite slot 3, then done lands on the expiry cycle: done wins
    push(32'h0, 32'd0);
    send(mk(3'b001, 3'd3, 5'd31), t);
    wait_rsp(r);
    eng_delay = TO; eng_res_v = 32'h55; eng_st_v = 32'd7;
    ac = abort_cnt;
    push(32'h55, 32'd7);
    send(mk(3'b011, 3'd3, 5'd31), t);
    wait_rsp(r);
    chk("edge_eng_args", {st_A, st_b, st_N}, {3'd3, 5'd31, 5'd31});
    chk("edge_rsp_latency", r, t + 3 + TO);
    chk("edge_no_abort", abort_cnt - ac, 0);

    // Timeout: engine never answers
    eng_delay = -1;
    ac = abort_cnt;
    push(32'h0, 32'd4);
    send(mk(3'b010, 3'd3, 5'd0), t);
    wait_rsp(r);
    chk("timeout_rsp_latency", r, t + 3 + TO);
    chk("timeout_abort_pulses", abort_cnt - ac, 1);
    chk("timeout_abort_cycle", abort_cyc, r);
    // Late done in IDLE must be ignored
    eng_done_s = 1'b1;
    @(posedge clk); #1;
    eng_done_s = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_done_ignored", {rsp_valid, cmd_ready}, {1'b0, 1'b1});

    // Backpressure: hold rsp_ready low for over 10 cycles
    rsp_ready = 1'b0;
    push(32'h0, 32'd0);
    send(mk(3'b001, 3'd5, 5'd2), t);
    wait_rsp(r);
    chk("hold_rsp_latency", r, t + 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_cmd_ready_low", {cmd_ready, rsp_valid}, {1'b0, 1'b1});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    rr = cyc;
    eng_delay = 3; eng_res_v = 32'h77; eng_st_v = 32'h0;
    push(32'h77, 32'd0);
    send(mk(3'b010, 3'd5, 5'd9), t);
    chk("accept_after_handshake", t, rr + 1);
    wait_rsp(r);
    chk("slot5_eng_args", {st_A, st_b, st_N}, {3'd5, 5'd1, 5'd2});

    // CLEAR invalidates slot 3
    push(32'h0, 32'd0);
    send(mk(3'b100, 3'd0, 5'd0), t);
    wait_rsp(r);
    push(32'h0, 32'd1);
    send(mk(3'b011, 3'd3, 5'd1), t);
    wait_rsp(r);

    // Reset during WAIT: silent abort, table cleared
    push(32'h0, 32'd0);
    send(mk(3'b001, 3'd3, 5'd4), t);
    wait_rsp(r);
    eng_delay = -1;
    sc = start_cnt;
    ac = abort_cnt;
    send(mk(3'b010, 3'd3, 5'd0), t);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_reset_started", start_cnt - sc, 1);
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {cmd_ready, eng_start, eng_abort, eng_A, eng_b, eng_N, rsp_valid},
        {1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 1'b0});
    chk("async_reset_rsp_data", {rsp_result, rsp_status}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (TO + 10) @(negedge clk);
    chk("no_rsp_after_reset", rsp_valid, 1'b0);
    chk("no_abort_after_reset", abort_cnt - ac, 0);
    sc = start_cnt;
    push(32'h0, 32'd1);
    send(mk(3'b010, 3'd3, 5'd0), t);
    wait_rsp(r);
    chk("table_cleared_no_start", start_cnt - sc, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
